txtbuf_arbiter: RTL and testbench
=================================

Name: txtbuf_arbiter

Overview:
Owns the 40x24 text-page RAM (960 bytes, CPU window 0x0400-0x07BF) and shares its single port between three requesters: the video fetch from vdp, a CPU read/write port, and an internal clear-screen sequencer. Video has absolute priority and fixed 1-cycle latency. The CPU uses a req/ack handshake. The clear engine fills idle cycles. Sits between vdp's adr/txt pins and the system bus, replacing the ad-hoc txtbuf array in framebuffer.

Parameters:
BASE, 16'h0400, CPU/video address of byte 0
SIZE, 960, bytes in the text page
FILL, 8'hA0, clear value and out-of-range read value
CLEAR_ON_RESET, 1, start a clear automatically after reset release

Ports:
CLOCK_50  in  1  sole clock; all logic on posedge
reset  in  1  asynchronous, active-low reset
vid_req  in  1  one-cycle strobe: vdp wants the byte at vid_adr
vid_adr  in  16  video address (absolute, BASE-relative decode internal)
vid_data  out  8  fetched byte
vid_valid  out  1  vid_data valid (one cycle)
cpu_req  in  1  CPU access request; held until cpu_ack
cpu_we  in  1  1=write, 0=read; stable while cpu_req
cpu_adr  in  16  CPU address
cpu_wdata  in  8  write data
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  8  read data, valid with cpu_ack
clr_start  in  1  strobe: fill whole page with FILL
clr_busy  out  1  clear in progress

Behaviour:
- Reset (reset=0, async): vid_data=0, vid_valid=0, cpu_ack=0, cpu_rdata=0, clr_busy=0, clear counter=0, FSM=IDLE. RAM contents not reset.
- CLEAR_ON_RESET=1: first posedge after reset release enters CLEAR; clr_busy=1 from that edge.
- Arbitration per cycle, one RAM access max: vid_req > pending CPU > clear step.
- Video: vid_req at edge N -> vid_data/vid_valid at edge N+1. Never stalled. Offset a=vid_adr-BASE; a>=SIZE (incl. wrap below BASE) -> vid_data=FILL, no RAM access needed but slot still consumed.
- CPU FSM: IDLE -> (cpu_req && !vid_req) ACCESS at grant edge G -> cpu_ack=1 at G+1 (state ACK). In ACK, cpu_req ignored; requester must drop req in ACK cycle; return to IDLE at G+2. Back-to-back CPU accesses therefore 2 cycles apart minimum. If vid_req collides, grant slips one cycle; no limit on slip (video strobes are sparse, at most 1 in 2 cycles).
- CPU read: cpu_rdata=RAM[a] with ack; out of range -> FILL. CPU write: RAM[a]=cpu_wdata at G; out of range -> no write, still acked.
- Clear: counter c 0..SIZE-1, writes FILL at c on any cycle with no video or CPU grant, increments; after writing SIZE-1 clr_busy drops next cycle. Minimum 960 cycles.
- clr_start during clear: restart at c=0. CPU write during clear: performed; may later be overwritten if c has not reached that address (documented, not prevented). Video reads during clear return current RAM contents.
- Reset mid-clear or mid-CPU-access: aborted, no ack issued, partial contents retained.
- Offset arithmetic 16-bit unsigned; RAM address 10 bits after range check.

Decomposition:
- Package txt_pkg: TXT_BASE, TXT_COLS=40, TXT_ROWS=24, TXT_SIZE=960, TXT_BLANK=8'hA0, arbiter state enum {IDLE, ACCESS, ACK}.
- Sub-module txt_ram: single-port 960x8, synchronous write, registered read (1-cycle), infers M10K.

Test Plan:
- Reset with CLEAR_ON_RESET=1 -> clr_busy high 960 cycles (no other traffic), then vid reads of 0x0400, 0x07BF return 8'hA0.
- CPU write 0x0410<=8'h48 -> cpu_ack exactly 2 edges after req asserted; subsequent CPU read returns 8'h48 with ack; vid read of 0x0410 returns 8'h48 next cycle.
- vid_req and cpu_req asserted same cycle, vid_adr=0x0400 -> vid_valid at N+1, cpu_ack delayed to N+2; both data correct.
- Out of range: CPU write 0x07C0<=8'h11 acked, RAM unchanged; vid read 0x03FF and 0x07C0 -> 8'hA0.
- clr_start at cycle 100 of an ongoing clear, then CPU write 0x0700<=8'h55 at cycle 110 -> final RAM[0x300]=8'hA0 (overwritten), clr_busy low after restart completes.
- Assert reset mid-CPU read -> no cpu_ack, all outputs 0 while low, FSM IDLE after release.

Source files
------------

// File: rtl/txt_pkg.sv
// Shared constants and types for the 40x24 text page.
// Used by the page RAM and the port arbiter.
package txt_pkg;

    localparam logic [15:0] TXT_BASE  = 16'h0400;
    localparam int          TXT_COLS  = 40;
    localparam int          TXT_ROWS  = 24;
    localparam int          TXT_SIZE  = TXT_COLS * TXT_ROWS;
    localparam logic [7:0]  TXT_BLANK = 8'hA0;
    localparam int          TXT_AW    = 10;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        ACK
    } arb_state_t;

    function automatic logic [15:0] page_off(
        input logic [15:0] adr,
        input logic [15:0] base
    );
        return adr - base;
    endfunction

endpackage

// File: rtl/txt_ram.sv
// Single-port text page storage.
// Synchronous write, registered read; maps onto one block RAM.
module txt_ram
    import txt_pkg::*;
#(
    parameter int DEPTH = TXT_SIZE
) (
    input  logic              CLOCK_50,
    input  logic              we,
    input  logic [TXT_AW-1:0] adr,
    input  logic [7:0]        wd,
    output logic [7:0]        q
);

    logic [7:0] mem [DEPTH];

    // Block RAM has no reset; read returns the pre-write contents.
    always_ff @(posedge CLOCK_50) begin
        if (we) mem[adr] <= wd;
        q <= mem[adr];
    end

endmodule

// File: rtl/txtbuf_arbiter.sv
// Text page owner: shares one RAM port between video,
// CPU and the clear sequencer (video > CPU > clear).
module txtbuf_arbiter
    import txt_pkg::*;
#(
    parameter logic [15:0] BASE           = TXT_BASE,
    parameter int          SIZE           = TXT_SIZE,
    parameter logic [7:0]  FILL           = TXT_BLANK,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        vid_req,
    input  logic [15:0] vid_adr,
    output logic [7:0]  vid_data,
    output logic        vid_valid,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_adr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    input  logic        clr_start,
    output logic        clr_busy
);

    localparam logic [15:0]       LIM  = 16'(SIZE);
    localparam logic [TXT_AW-1:0] LAST = TXT_AW'(SIZE - 1);

    arb_state_t        state_q, state_d;
    logic [15:0]       vid_off, cpu_off;
    logic              vid_in, cpu_in;
    logic              cpu_grant, clr_step;
    logic              ram_we;
    logic [TXT_AW-1:0] ram_adr;
    logic [7:0]        ram_wd, ram_q;
    logic [TXT_AW-1:0] clr_cnt;
    logic              boot_q;
    logic              vid_pend, vid_oor, cpu_oor;

    assign vid_off   = page_off(vid_adr, BASE);
    assign cpu_off   = page_off(cpu_adr, BASE);
    assign vid_in    = vid_off < LIM;
    assign cpu_in    = cpu_off < LIM;
    assign cpu_grant = (state_q == IDLE) && cpu_req && !vid_req;
    assign clr_step  = clr_busy && !vid_req && !cpu_grant
                     && !clr_start;

    txt_ram #(.DEPTH(SIZE)) u_ram (
        .CLOCK_50 (CLOCK_50),
        .we       (ram_we),
        .adr      (ram_adr),
        .wd       (ram_wd),
        .q        (ram_q)
    );

    // Steer the single RAM port to this cycle's winner.
    always_comb begin
        ram_we  = 1'b0;
        ram_adr = '0;
        ram_wd  = FILL;
        unique case (1'b1)
            vid_req: begin
                ram_adr = vid_off[TXT_AW-1:0];
            end
            cpu_grant: begin
                ram_adr = cpu_off[TXT_AW-1:0];
                ram_we  = cpu_we && cpu_in;
                ram_wd  = cpu_wdata;
            end
            clr_step: begin
                ram_adr = clr_cnt;
                ram_we  = 1'b1;
            end
            default: ;
        endcase
    end

    // CPU handshake: grant, return data, then one ack cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cpu_grant) state_d = ACCESS;
            ACCESS:  state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // CPU state register.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Video return path: fixed one-cycle latency.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            vid_pend  <= 1'b0;
            vid_oor   <= 1'b0;
            vid_valid <= 1'b0;
            vid_data  <= '0;
        end else begin
            vid_pend  <= vid_req;
            vid_oor   <= !vid_in;
            vid_valid <= vid_pend;
            if (vid_pend) vid_data <= vid_oor ? FILL : ram_q;
        end
    end

    // CPU return path: ack and read data one cycle after grant.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            cpu_oor   <= 1'b0;
            cpu_ack   <= 1'b0;
            cpu_rdata <= '0;
        end else begin
            if (cpu_grant) cpu_oor <= !cpu_in;
            cpu_ack <= (state_q == ACCESS);
            if (state_q == ACCESS && !cpu_we)
                cpu_rdata <= cpu_oor ? FILL : ram_q;
        end
    end

    // Clear sequencer: walks the page using otherwise idle slots.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            boot_q   <= CLEAR_ON_RESET;
            clr_busy <= 1'b0;
            clr_cnt  <= '0;
        end else begin
            boot_q <= 1'b0;
            if (boot_q || clr_start) begin
                clr_busy <= 1'b1;
                clr_cnt  <= '0;
            end else if (clr_step) begin
                if (clr_cnt == LAST) begin
                    clr_busy <= 1'b0;
                    clr_cnt  <= '0;
                end else begin
                    clr_cnt <= clr_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_txtbuf_arbiter.sv
// Bench for the text page arbiter: directed scenarios
// plus a randomized run against a byte-array page model.
module tb_txtbuf_arbiter;

    localparam logic [15:0] BASE = 16'h0400;
    localparam int          SIZE = 960;
    localparam logic [7:0]  FILL = 8'hA0;

    logic        CLOCK_50 = 1'b0;
    logic        reset = 1'b0;
    logic        vid_req = 1'b0;
    logic [15:0] vid_adr = '0;
    logic [7:0]  vid_data;
    logic        vid_valid;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [15:0] cpu_adr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        clr_start = 1'b0;
    logic        clr_busy;

    int tests = 0;
    int fails = 0;

    logic [7:0] model [SIZE];

    always #10 CLOCK_50 = ~CLOCK_50;

    txtbuf_arbiter dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .vid_req   (vid_req),
        .vid_adr   (vid_adr),
        .vid_data  (vid_data),
        .vid_valid (vid_valid),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_adr   (cpu_adr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .clr_start (clr_start),
        .clr_busy  (clr_busy)
    );

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    function automatic int page_index(input logic [15:0] adr);
        return int'({16'h0, adr}) - int'({16'h0, BASE});
    endfunction

    function automatic logic [7:0] ref_rd(input logic [15:0] adr);
        int off;
        off = page_index(adr);
        if (off < 0 || off >= SIZE) return FILL;
        return model[off];
    endfunction

    function automatic void ref_wr(input logic [15:0] adr,
                                   input logic [7:0] d);
        int off;
        off = page_index(adr);
        if (off >= 0 && off < SIZE) model[off] = d;
    endfunction

    function automatic void fill_model();
        for (int i = 0; i < SIZE; i++) model[i] = FILL;
    endfunction

    function automatic logic [15:0] rand_adr();
        case ($urandom_range(0, 9))
            0: return 16'($urandom);
            1: return BASE - 16'($urandom_range(1, 4));
            2: return BASE + 16'(SIZE + $urandom_range(0, 3));
            3: return BASE + 16'($urandom_range(0, SIZE - 1));
            default: return BASE + 16'($urandom_range(0, 15));
        endcase
    endfunction

    task automatic vid_read(input logic [15:0] adr,
                            output logic v, output logic [7:0] d);
        vid_req = 1'b1;
        vid_adr = adr;
        tick();
        vid_req = 1'b0;
        tick();
        v = vid_valid;
        d = vid_data;
    endtask

    task automatic cpu_access(input logic we,
                              input logic [15:0] adr,
                              input logic [7:0] wd,
                              output logic [7:0] rd,
                              output int edges);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_adr   = adr;
        cpu_wdata = wd;
        edges     = 0;
        do begin
            tick();
            edges++;
        end while (cpu_ack !== 1'b1 && edges < 16);
        rd = cpu_rdata;
        cpu_req = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        int n;
        logic v;
        logic [7:0] d;
        reset = 1'b0;
        repeat (3) tick();
        tests++;
        if ({vid_data, vid_valid, cpu_ack, cpu_rdata, clr_busy} !== '0) begin
            fails++;
            $display("FAIL reset_outs: got %h/%b/%b/%h/%b want all 0",
                     vid_data, vid_valid, cpu_ack, cpu_rdata, clr_busy);
        end
        #3 reset = 1'b1;
        tick();
        tests++;
        if (clr_busy !== 1'b1) begin
            fails++;
            $display("FAIL boot_busy: got %b want 1", clr_busy);
        end
        n = 1;
        while (clr_busy === 1'b1 && n < 2000) begin
            tick();
            if (clr_busy === 1'b1) n++;
        end
        tests++;
        if (n != 960) begin
            fails++;
            $display("FAIL boot_len: got %0d want 960", n);
        end
        fill_model();
        vid_read(16'h0400, v, d);
        tests++;
        if ({v, d} !== {1'b1, FILL}) begin
            fails++;
            $display("FAIL vid_0400: got %b/%h want 1/%h", v, d, FILL);
        end
        vid_read(16'h07BF, v, d);
        tests++;
        if ({v, d} !== {1'b1, FILL}) begin
            fails++;
            $display("FAIL vid_07bf: got %b/%h want 1/%h", v, d, FILL);
        end
    endtask

    task automatic test_cpu_rw();
        int e;
        logic v;
        logic [7:0] d;
        cpu_access(1'b1, 16'h0410, 8'h48, d, e);
        ref_wr(16'h0410, 8'h48);
        tests++;
        if (e != 2) begin
            fails++;
            $display("FAIL wr_ack_lat: got %0d want 2", e);
        end
        cpu_access(1'b0, 16'h0410, 8'h00, d, e);
        tests++;
        if (e != 2 || d !== 8'h48) begin
            fails++;
            $display("FAIL rd_0410: got %0d/%h want 2/48", e, d);
        end
        vid_read(16'h0410, v, d);
        tests++;
        if ({v, d} !== {1'b1, 8'h48}) begin
            fails++;
            $display("FAIL vid_0410: got %b/%h want 1/48", v, d);
        end
    endtask

    task automatic test_collision();
        vid_req   = 1'b1;
        vid_adr   = 16'h0400;
        cpu_req   = 1'b1;
        cpu_we    = 1'b0;
        cpu_adr   = 16'h0410;
        tick();
        vid_req = 1'b0;
        tick();
        tests++;
        if ({vid_valid, vid_data, cpu_ack} !== {1'b1, FILL, 1'b0}) begin
            fails++;
            $display("FAIL coll_n1: got %b/%h/%b want 1/a0/0",
                     vid_valid, vid_data, cpu_ack);
        end
        tick();
        tests++;
        if ({cpu_ack, cpu_rdata, vid_valid} !== {1'b1, 8'h48, 1'b0}) begin
            fails++;
            $display("FAIL coll_n2: got %b/%h/%b want 1/48/0",
                     cpu_ack, cpu_rdata, vid_valid);
        end
        cpu_req = 1'b0;
        tick();
    endtask

    task automatic test_out_of_range();
        int e;
        logic v;
        logic [7:0] d;
        logic [15:0] adrs [4];
        logic [7:0]  exps [4];
        cpu_access(1'b1, 16'h07C0, 8'h11, d, e);
        tests++;
        if (e != 2) begin
            fails++;
            $display("FAIL oor_wr_ack: got %0d want 2", e);
        end
        cpu_access(1'b0, 16'h07C0, 8'h00, d, e);
        tests++;
        if (e != 2 || d !== FILL) begin
            fails++;
            $display("FAIL oor_rd_07c0: got %0d/%h want 2/a0", e, d);
        end
        cpu_access(1'b0, 16'h03FF, 8'h00, d, e);
        tests++;
        if (e != 2 || d !== FILL) begin
            fails++;
            $display("FAIL oor_rd_03ff: got %0d/%h want 2/a0", e, d);
        end
        adrs = '{16'h03FF, 16'h07C0, 16'h0400, 16'h0410};
        exps = '{FILL, FILL, FILL, 8'h48};
        for (int i = 0; i < 4; i++) begin
            vid_read(adrs[i], v, d);
            tests++;
            if ({v, d} !== {1'b1, exps[i]}) begin
                fails++;
                $display("FAIL oor_vid_%h: got %b/%h want 1/%h",
                         adrs[i], v, d, exps[i]);
            end
        end
    endtask

    task automatic test_clear_restart();
        int k;
        bit acked;
        logic v;
        logic [7:0] d;
        int e;
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        repeat (99) tick();
        tests++;
        if (clr_busy !== 1'b1) begin
            fails++;
            $display("FAIL clr_mid: got %b want 1", clr_busy);
        end
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        k = 1;
        acked = 1'b0;
        while (k < 3000) begin
            if (k == 10) begin
                cpu_req   = 1'b1;
                cpu_we    = 1'b1;
                cpu_adr   = 16'h0700;
                cpu_wdata = 8'h55;
            end
            tick();
            if (cpu_ack === 1'b1) begin
                cpu_req = 1'b0;
                acked = 1'b1;
            end
            if (clr_busy !== 1'b1) break;
            k++;
        end
        cpu_req = 1'b0;
        tests++;
        if (!acked || k != 961) begin
            fails++;
            $display("FAIL clr_restart: got ack=%0b len=%0d want 1/961",
                     acked, k);
        end
        fill_model();
        vid_read(16'h0700, v, d);
        tests++;
        if ({v, d} !== {1'b1, FILL}) begin
            fails++;
            $display("FAIL clr_overwrite: got %b/%h want 1/a0", v, d);
        end
        cpu_access(1'b0, 16'h0410, 8'h00, d, e);
        tests++;
        if (d !== FILL) begin
            fails++;
            $display("FAIL clr_0410: got %h want a0", d);
        end
    endtask

    task automatic test_reset_mid();
        int e;
        int n;
        logic [7:0] d;
        cpu_req = 1'b1;
        cpu_we  = 1'b0;
        cpu_adr = 16'h0400;
        tick();
        reset = 1'b0;
        #1;
        tests++;
        if ({vid_data, vid_valid, cpu_ack, cpu_rdata, clr_busy} !== '0) begin
            fails++;
            $display("FAIL rst_mid_outs: got %h/%b/%b/%h/%b want all 0",
                     vid_data, vid_valid, cpu_ack, cpu_rdata, clr_busy);
        end
        cpu_req = 1'b0;
        tick();
        tests++;
        if (cpu_ack !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_ack: got %b want 0", cpu_ack);
        end
        tick();
        reset = 1'b1;
        cpu_access(1'b0, 16'h0400, 8'h00, d, e);
        tests++;
        if (e != 2 || d !== FILL) begin
            fails++;
            $display("FAIL rst_mid_idle: got %0d/%h want 2/a0", e, d);
        end
        n = 0;
        while (clr_busy === 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        tests++;
        if (clr_busy !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_clr: got %b want 0", clr_busy);
        end
        fill_model();
    endtask

    task automatic test_random();
        logic        s_vid, s_cpu, s_we;
        logic [15:0] s_vadr, s_cadr;
        logic [7:0]  s_wd;
        logic        exp_v, exp_ack, exp_chk, ack_now;
        logic [7:0]  exp_vd, exp_rd;
        bit          granted;
        exp_v = 0; exp_ack = 0; exp_chk = 0;
        exp_vd = '0; exp_rd = '0; granted = 0;
        vid_req = 1'b0;
        cpu_req = 1'b0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            s_vid  = vid_req;
            s_vadr = vid_adr;
            s_cpu  = cpu_req;
            s_we   = cpu_we;
            s_cadr = cpu_adr;
            s_wd   = cpu_wdata;
            tick();
            tests++;
            if (vid_valid !== exp_v ||
                (exp_v && vid_data !== exp_vd)) begin
                fails++;
                $display("FAIL rnd_vid@%0d: got %b/%h want %b/%h",
                         cyc, vid_valid, vid_data, exp_v, exp_vd);
            end
            tests++;
            if (cpu_ack !== exp_ack ||
                (exp_ack && exp_chk && cpu_rdata !== exp_rd)) begin
                fails++;
                $display("FAIL rnd_cpu@%0d: got %b/%h want %b/%h",
                         cyc, cpu_ack, cpu_rdata, exp_ack, exp_rd);
            end
            exp_v = s_vid;
            if (s_vid) exp_vd = ref_rd(s_vadr);
            ack_now = exp_ack;
            exp_ack = 1'b0;
            if (s_cpu && !s_vid && !granted) begin
                granted = 1;
                exp_ack = 1'b1;
                exp_chk = !s_we;
                if (s_we) ref_wr(s_cadr, s_wd);
                else      exp_rd = ref_rd(s_cadr);
            end
            vid_req = !s_vid && ($urandom_range(0, 2) == 0);
            vid_adr = rand_adr();
            if (ack_now) begin
                cpu_req = 1'b0;
                granted = 0;
            end else if (!cpu_req && $urandom_range(0, 1) == 1) begin
                cpu_req   = 1'b1;
                cpu_we    = 1'($urandom_range(0, 1));
                cpu_adr   = rand_adr();
                cpu_wdata = 8'($urandom);
            end
        end
        vid_req = 1'b0;
        cpu_req = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        test_reset();
        test_cpu_rw();
        test_collision();
        test_out_of_range();
        test_clear_restart();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
